masked_and_isw_pipe: RTL
========================

// Module: masked_and_isw_pipe
// PURPOSE
//  NSHARES-share ISW masked AND gadget: c = a & b over Boolean shares, with z fresh random bits.
//  Generalises the fixed 3-share combinational gadget to any share count.
//  Adds a 2-stage register pipeline that freezes ISW partial-sum ordering against glitches.
//  Carries valid/ready on operands, randomness and result; sits between masked datapath stages
//  in leakage-verified accelerators.
// PARAMETERS
//  NSHARES  3  number of shares per operand (>=2)
//  NRND     NSHARES*(NSHARES-1)/2  fresh random bits per op (derived localparam, not overridable)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        synchronous, active-high reset
//  a          in   NSHARES  shares of operand a, bit i = share i
//  b          in   NSHARES  shares of operand b
//  in_valid   in   1        a/b valid
//  in_ready   out  1        gadget can take a/b this cycle
//  z          in   NRND     fresh randomness, bit pidx(i,j) = z_ij, i<j
//  rnd_valid  in   1        z valid
//  rnd_ready  out  1        z consumed this cycle
//  c          out  NSHARES  result shares, bit i = share i
//  out_valid  out  1        c valid
//  out_ready  in   1        downstream takes c
// BEHAVIOUR
//  - pidx(i,j) = i*NSHARES - i*(i+1)/2 + (j-i-1), i<j; N=3 gives z01->0, z02->1, z12->2.
//  - accept = in_valid & rnd_valid & in_ready; rnd_ready = accept. No partial consumption.
//  - in_ready = !s1_v | s1_adv; s1_adv = s1_v & (!s2_v | out_ready); out_valid = s2_v.
//  - Stage 1 loads on accept:
//      d_i = a_i&b_i; for i<j: r_ij = z_ij, t_ij = (a_i&b_j)^z_ij, p_ij = a_j&b_i.
//      Each term is its own flop; no XOR of raw products beyond t_ij.
//  - Stage 2 loads on s1_adv:
//      c_i = d_i ^ XOR_{j>i} r_ij ^ XOR_{j<i} (t_ji ^ p_ji).
//      XOR in ascending j; (t ^ p) formed before joining the sum.
//  - Latency: 2 cycles accept->out_valid. Throughput 1/cycle while out_ready=1.
//  - Stall: with out_valid=1 and out_ready=0, c and stage-1 hold; in_ready=0 once both stages full.
//  - Simultaneous accept and s1_adv in one cycle: stage 1 reloads, no bubble.
//  - Reset: s1_v, s2_v, all stage flops and c = 0. in_ready=1 and out_valid=0 in the cycle after rst.
//    Reset mid-flight drops in-flight ops without output.
//  - Invariant: XOR(c) = XOR(a) & XOR(b) for every output, whatever z.
// STRUCTURE
//  - Package masking_pkg: function nrnd(n), function pidx(i,j,n), localparam MIN_SHARES=2.
//  - One sub-module masked_pipe_reg #(W): valid/data register with load/clear. Instantiated per stage.
//  - Generate loops over (i,j); elaboration $error if NSHARES<2.
// TESTING
//  1 N=3, a=101, b=011, z=000 -> 2 cycles later c=011, out_valid=1.
//  2 N=3, a=111, b=001, z=101 -> c=010 (XOR=1).
//  3 out_ready=0 for 4 cycles, 3 ops offered:
//    -> 2 accepted, then in_ready=0; c held stable; all 3 emitted in order once ready.
//  4 in_valid=1, rnd_valid=0 for 2 cycles -> no accept, rnd_ready=0; accept on the cycle rnd_valid rises.
//  5 rst asserted with both stages full -> next cycle out_valid=0, c=0, in_ready=1; no stale op emitted.
//  6 N=2 and N=5: exhaustive/random a,b,z, 1 op/cycle -> XOR(c)==XOR(a)&XOR(b) every output, zero bubbles.

Source files
------------

// File: rtl/masked_and_isw_pipe_pkg.sv
// Shared helpers for the masked AND gadgets: randomness budget and pair-to-bit mapping
// for the fresh random bits z_ij (i < j).
package masking_pkg;

    localparam int MIN_SHARES = 2;

    function automatic int nrnd(input int n);
        return (n * (n - 1)) / 2;
    endfunction

    // Row-major packing of the strict upper triangle: (0,1),(0,2),..,(1,2),..
    function automatic int pidx(input int i, input int j, input int n);
        return (i * n) - ((i * (i + 1)) / 2) + (j - i - 1);
    endfunction

endpackage

// File: rtl/masked_and_isw_pipe_if.sv
// Operand, randomness and result channels of the masked AND pipeline.
// The master side drives operands/randomness and consumes results.
interface masked_and_isw_pipe_if #(
    parameter int NSHARES = 3
);
    import masking_pkg::*;

    localparam int NRND = nrnd(NSHARES);

    logic [NSHARES-1:0] a;
    logic [NSHARES-1:0] b;
    logic               in_valid;
    logic               in_ready;
    logic [NRND-1:0]    z;
    logic               rnd_valid;
    logic               rnd_ready;
    logic [NSHARES-1:0] c;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output a, b, in_valid, z, rnd_valid, out_ready,
        input  in_ready, rnd_ready, c, out_valid
    );

    modport slave (
        input  a, b, in_valid, z, rnd_valid, out_ready,
        output in_ready, rnd_ready, c, out_valid
    );

endinterface

// File: rtl/masked_and_isw_pipe_reg.sv
// Valid/data pipeline register: load captures data and sets valid, clear drops valid
// while keeping data; load wins over clear.
module masked_pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Stage valid flag and payload
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/masked_and_isw_pipe.sv
// NSHARES-share ISW masked AND with a two-stage register pipeline; stage 1 holds every
// partial product separately so the stage-2 XOR tree sees only glitch-free inputs.
module masked_and_isw_pipe
    import masking_pkg::*;
#(
    parameter int NSHARES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    masked_and_isw_pipe_if.slave  bus
);

    localparam int NRND = nrnd(NSHARES);
    localparam int S1W  = NSHARES + (3 * NRND);

    if (NSHARES < MIN_SHARES) begin : g_bad_shares
        $error("masked_and_isw_pipe: NSHARES must be at least 2");
    end

    logic               w_accept;
    logic               w_s1_adv;
    logic               w_s1_v;
    logic               w_s2_v;
    logic [NSHARES-1:0] w_d;
    logic [NRND-1:0]    w_r;
    logic [NRND-1:0]    w_t;
    logic [NRND-1:0]    w_p;
    logic [S1W-1:0]     w_s1_q;
    logic [NSHARES-1:0] w_s1_d;
    logic [NRND-1:0]    w_s1_r;
    logic [NRND-1:0]    w_s1_t;
    logic [NRND-1:0]    w_s1_p;
    logic [NSHARES-1:0] w_c_next;
    logic [NSHARES-1:0] w_s2_q;

    assign w_s1_adv      = w_s1_v & (~w_s2_v | bus.out_ready);
    assign bus.in_ready  = ~w_s1_v | w_s1_adv;
    assign w_accept      = bus.in_valid & bus.rnd_valid & bus.in_ready;
    assign bus.rnd_ready = w_accept;

    for (genvar gi = 0; gi < NSHARES; gi++) begin : g_row
        assign w_d[gi] = bus.a[gi] & bus.b[gi];
        for (genvar gj = gi + 1; gj < NSHARES; gj++) begin : g_col
            localparam int K = pidx(gi, gj, NSHARES);
            // z is folded into the i<j cross product only; the j>i mirror stays raw
            assign w_r[K] = bus.z[K];
            assign w_t[K] = (bus.a[gi] & bus.b[gj]) ^ bus.z[K];
            assign w_p[K] = bus.a[gj] & bus.b[gi];
        end
    end

    masked_pipe_reg #(.W(S1W)) u_stage1 (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_clear (w_s1_adv),
        .i_data  ({w_p, w_t, w_r, w_d}),
        .o_valid (w_s1_v),
        .o_data  (w_s1_q)
    );

    assign w_s1_d = w_s1_q[0 +: NSHARES];
    assign w_s1_r = w_s1_q[NSHARES +: NRND];
    assign w_s1_t = w_s1_q[(NSHARES + NRND) +: NRND];
    assign w_s1_p = w_s1_q[(NSHARES + (2 * NRND)) +: NRND];

    // Per-share compression: own product, then masks, then (t ^ p) pairs, ascending j
    always_comb begin
        w_c_next = '0;
        for (int i = 0; i < NSHARES; i++) begin
            w_c_next[i] = w_s1_d[i];
            for (int j = i + 1; j < NSHARES; j++) begin
                w_c_next[i] = w_c_next[i] ^ w_s1_r[pidx(i, j, NSHARES)];
            end
            for (int j = 0; j < i; j++) begin
                w_c_next[i] = w_c_next[i]
                            ^ (w_s1_t[pidx(j, i, NSHARES)] ^ w_s1_p[pidx(j, i, NSHARES)]);
            end
        end
    end

    masked_pipe_reg #(.W(NSHARES)) u_stage2 (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_s1_adv),
        .i_clear (w_s2_v & bus.out_ready),
        .i_data  (w_c_next),
        .o_valid (w_s2_v),
        .o_data  (w_s2_q)
    );

    assign bus.out_valid = w_s2_v;
    assign bus.c         = w_s2_q;

endmodule
